// File: rtl/sc_level_sequencer.sv
// RoadFighter game-level sequencer: owns level and lives, pulses clear/load to the
// level datapath, gates scrolling and handles crash, respawn, game-over and win.
module sc_level_sequencer #(
    parameter int unsigned NUM_LEVELS     = 3,
    parameter int unsigned ROWS_PER_LEVEL = 64,
    parameter int unsigned LIVES          = 3,
    parameter int unsigned DEAD_CYCLES    = 16
) (
    input  logic       SC_LEVEL_SEQUENCER_CLOCK_50,
    input  logic       SC_LEVEL_SEQUENCER_RESET_InHigh,
    input  logic       SC_LEVEL_SEQUENCER_startButton_InLow,
    input  logic       SC_LEVEL_SEQUENCER_crash_InLow,
    input  logic       SC_LEVEL_SEQUENCER_rowTick_InHigh,
    output logic       SC_LEVEL_SEQUENCER_clear_OutLow,
    output logic       SC_LEVEL_SEQUENCER_load_OutLow,
    output logic       SC_LEVEL_SEQUENCER_run_OutHigh,
    output logic [1:0] SC_LEVEL_SEQUENCER_level_Out,
    output logic [1:0] SC_LEVEL_SEQUENCER_lives_Out,
    output logic       SC_LEVEL_SEQUENCER_gameOver_OutHigh,
    output logic       SC_LEVEL_SEQUENCER_win_OutHigh
);

    localparam int unsigned RowW  = (ROWS_PER_LEVEL > 1) ? $clog2(ROWS_PER_LEVEL) : 1;
    localparam int unsigned DeadW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    localparam logic [RowW-1:0]  RowLast   = RowW'(ROWS_PER_LEVEL - 1);
    localparam logic [DeadW-1:0] DeadLast  = DeadW'(DEAD_CYCLES - 1);
    localparam logic [1:0]       LevelLast = 2'(NUM_LEVELS);
    localparam logic [1:0]       LivesInit = 2'(LIVES);

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StWaitRel  = 4'd1,
        StClear    = 4'd2,
        StLoad     = 4'd3,
        StPlay     = 4'd4,
        StLvlUp    = 4'd5,
        StDead     = 4'd6,
        StGameOver = 4'd7,
        StWin      = 4'd8,
        StWaitRel2 = 4'd9,
        StRestart  = 4'd10
    } seqState;

    seqState          stateQ, stateD;
    logic [1:0]       levelQ, levelD;
    logic [1:0]       livesQ, livesD;
    logic [RowW-1:0]  rowCntQ, rowCntD;
    logic [DeadW-1:0] deadCntQ, deadCntD;

    logic startPressed;
    logic crashActive;

    assign startPressed = ~SC_LEVEL_SEQUENCER_startButton_InLow;
    assign crashActive  = ~SC_LEVEL_SEQUENCER_crash_InLow;

    always_ff @(posedge SC_LEVEL_SEQUENCER_CLOCK_50 or posedge SC_LEVEL_SEQUENCER_RESET_InHigh) begin
        if (SC_LEVEL_SEQUENCER_RESET_InHigh) begin
            stateQ   <= StIdle;
            levelQ   <= 2'd1;
            livesQ   <= LivesInit;
            rowCntQ  <= '0;
            deadCntQ <= '0;
        end else begin
            stateQ   <= stateD;
            levelQ   <= levelD;
            livesQ   <= livesD;
            rowCntQ  <= rowCntD;
            deadCntQ <= deadCntD;
        end
    end

    always_comb begin
        stateD   = stateQ;
        levelD   = levelQ;
        livesD   = livesQ;
        rowCntD  = rowCntQ;
        deadCntD = deadCntQ;

        case (stateQ)
            StIdle: begin
                if (startPressed) stateD = StWaitRel;
            end
            // Act on release so a held button starts exactly one game.
            StWaitRel: begin
                if (!startPressed) stateD = StClear;
            end
            StClear: begin
                stateD = StLoad;
            end
            StLoad: begin
                rowCntD = '0;
                stateD  = StPlay;
            end
            StPlay: begin
                // Crash wins over a same-cycle row tick; that tick is dropped.
                if (crashActive) begin
                    stateD   = StDead;
                    deadCntD = '0;
                    if (livesQ != 2'd0) livesD = livesQ - 2'd1;
                end else if (SC_LEVEL_SEQUENCER_rowTick_InHigh) begin
                    if (rowCntQ == RowLast) begin
                        stateD = StLvlUp;
                    end else begin
                        rowCntD = rowCntQ + RowW'(1);
                    end
                end
            end
            StLvlUp: begin
                if (levelQ == LevelLast) begin
                    stateD = StWin;
                end else begin
                    levelD = levelQ + 2'd1;
                    stateD = StClear;
                end
            end
            // Respawn reloads the same level without a clear pulse.
            StDead: begin
                if (deadCntQ == DeadLast) begin
                    stateD = (livesQ == 2'd0) ? StGameOver : StLoad;
                end else begin
                    deadCntD = deadCntQ + DeadW'(1);
                end
            end
            StGameOver, StWin: begin
                if (startPressed) stateD = StWaitRel2;
            end
            StWaitRel2: begin
                if (!startPressed) stateD = StRestart;
            end
            StRestart: begin
                levelD = 2'd1;
                livesD = LivesInit;
                stateD = StClear;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    assign SC_LEVEL_SEQUENCER_clear_OutLow      = (stateQ != StClear);
    assign SC_LEVEL_SEQUENCER_load_OutLow       = (stateQ != StLoad);
    assign SC_LEVEL_SEQUENCER_run_OutHigh       = (stateQ == StPlay);
    assign SC_LEVEL_SEQUENCER_gameOver_OutHigh  = (stateQ == StGameOver);
    assign SC_LEVEL_SEQUENCER_win_OutHigh       = (stateQ == StWin);
    assign SC_LEVEL_SEQUENCER_level_Out         = levelQ;
    assign SC_LEVEL_SEQUENCER_lives_Out         = livesQ;

endmodule
